nios2_oci_dct_packer: RTL and testbench
=======================================

// Module: nios2_oci_dct_packer
// PURPOSE
//  Packs per-cycle OCI data-trace atoms into a 30-bit compressed-trace word with a slot count.
//  Produces dct_buffer/dct_count for the OCI trace path and the OCI test-bench monitor.
//  Sits between the dtrace atom generator (upstream) and the trace FIFO/test bench (downstream).
//  Two-register design: an accumulator, plus an output holding register with valid/ready.
// PARAMETERS
//  ATOM_W  3   bits per trace atom
//  SLOTS   10  atoms per packed word; ATOM_W*SLOTS must equal 30; SLOTS <= 15
// PORTS
//  clk           in   1   system clock, all logic on rising edge
//  reset_n       in   1   asynchronous active-low reset
//  atm_valid     in   1   atom present on atm
//  atm           in   3   trace atom
//  atm_ready     out  1   atom accepted when atm_valid && atm_ready
//  flush         in   1   one-cycle request: emit partial word
//  test_ending   in   1   level: treated as flush on every cycle it is high
//  dct_buffer    out  30  packed word; slot k = bits [3k+2:3k]; unused slots zero
//  dct_count     out  4   number of valid slots in dct_buffer (1..10 when dct_valid)
//  dct_valid     out  1   output word valid; held until dct_ready
//  dct_ready     in   1   downstream consumes word when dct_valid && dct_ready
// BEHAVIOUR
//  Reset: acc_buf=0, acc_cnt=0, flush_pend=0, dct_buffer=0, dct_count=0, dct_valid=0.
//  Reset mid-operation discards the accumulator and any held word; no partial emit.
//  Accept: the atom is written to slot acc_cnt, then acc_cnt+1.
//  flush_req = flush | test_ending, evaluated against acc_cnt before this cycle's atom.
//  flush_req with acc_cnt==0 is dropped; with acc_cnt>0 it sets flush_pend.
//  xfer = (acc_cnt==SLOTS || flush_pend || (flush_req && acc_cnt!=0))
//         && (!dct_valid || dct_ready).
//  On xfer: dct_buffer<=acc_buf, dct_count<=acc_cnt, dct_valid<=1, flush_pend<=0.
//    The accumulator restarts: if an atom is accepted in the same cycle, it goes to slot0
//    and acc_cnt<=1; otherwise acc_buf<=0 and acc_cnt<=0.
//  Without xfer, a consume (dct_valid && dct_ready) clears dct_valid; data holds its value.
//  atm_ready = (acc_cnt != SLOTS) || xfer   (combinational, no reg-to-reg bubble).
//  Full + output blocked: atm_ready=0 and the atom is stalled, never dropped.
//  Word reaching SLOTS on accept: emitted the next cycle if output free (1-cycle latency).
//  Flush latency: dct_valid rises 1 cycle after flush_req if the output is free.
//  flush_req while output blocked: flush_pend holds until xfer.
//  Throughput: one word per SLOTS accepted atoms with dct_ready held high; no stall cycles.
// CONFIGURATION
//  NIOS2_OCI_DCT_OVF_CNT_EN defined: adds output dct_ovf_cnt[7:0] (reset 0).
//    It increments, saturating at 255, on each cycle with atm_valid && !atm_ready.
//    It is cleared by a flush_req that causes an xfer.
//  Not defined: port absent, no counter logic; all other behaviour is identical.
// TESTING
//  10 atoms 1..7,0,1,2 back-to-back, dct_ready=1 -> one dct_valid pulse.
//    Expected word: dct_count=10, dct_buffer=30'o2107654321.
//  3 atoms 5,6,7 then flush -> next cycle dct_count=3, dct_buffer=30'o765.
//    A flush at acc_cnt=0 produces no word.
//  dct_ready=0, 25 atoms offered -> words 1 and 2 fill, then atm_ready=0.
//    Raise dct_ready: word1, then word2, then 5 more accepted; no atom lost or reordered.
//  Atom on the same cycle as xfer of a full word -> new word starts at slot0, acc_cnt=1.
//  test_ending held high with sparse atoms -> each atom emitted alone with dct_count=1.
//  reset_n low mid-word with dct_valid=1 -> all outputs 0 asynchronously.
//    After release, the next word starts at slot0.
//  With NIOS2_OCI_DCT_OVF_CNT_EN: 4 stalled cycles -> dct_ovf_cnt=4.
//    A flush causing xfer -> dct_ovf_cnt=0.

Source files
------------

// File: rtl/nios2_oci_dct_packer.sv
// Packs 3-bit OCI data-trace atoms into a 30-bit word with a slot count; full word or flush emits 1 cycle later.
// Backpressure: a held output word stalls atm_ready only once the accumulator is full; optional NIOS2_OCI_DCT_OVF_CNT_EN adds a stall counter.
module nios2_oci_dct_packer #(
  parameter int ATOM_W = 3,
  parameter int SLOTS  = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    atm_valid,
  input  logic [ATOM_W-1:0]       atm,
  output logic                    atm_ready,
  input  logic                    flush,
  input  logic                    test_ending,
  output logic [ATOM_W*SLOTS-1:0] dct_buffer,
  output logic [3:0]              dct_count,
  output logic                    dct_valid,
  input  logic                    dct_ready
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
  ,
  output logic [7:0]              dct_ovf_cnt
`endif
);

  localparam int W = ATOM_W * SLOTS;
  localparam logic [3:0] SLOTS_C = 4'(SLOTS);

  logic [W-1:0] acc_buf;
  logic [3:0]   acc_cnt;
  logic         flush_pend;

  logic         flush_req;
  logic         acc_full;
  logic         xfer;
  logic         accept;
  logic [W-1:0] acc_buf_ins;
  logic [W-1:0] acc_buf_first;

  // flush_req is judged against the count before this cycle's atom lands
  assign flush_req = flush | test_ending;
  assign acc_full  = (acc_cnt == SLOTS_C);
  assign xfer      = (acc_full || flush_pend || (flush_req && (acc_cnt != 4'd0)))
                     && (!dct_valid || dct_ready);
  assign atm_ready = !acc_full || xfer;
  assign accept    = atm_valid && atm_ready;

  always_comb begin
    acc_buf_ins = acc_buf;
    for (int k = 0; k < SLOTS; k++) begin
      if (acc_cnt == 4'(k)) begin
        acc_buf_ins[k*ATOM_W +: ATOM_W] = atm;
      end
    end
    acc_buf_first                = '0;
    acc_buf_first[ATOM_W-1:0]    = atm;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_buf    <= '0;
      acc_cnt    <= 4'd0;
      flush_pend <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= 4'd0;
      dct_valid  <= 1'b0;
    end else if (xfer) begin
      dct_buffer <= acc_buf;
      dct_count  <= acc_cnt;
      dct_valid  <= 1'b1;
      flush_pend <= 1'b0;
      // an atom arriving with the transfer opens the next word at slot 0
      if (accept) begin
        acc_buf <= acc_buf_first;
        acc_cnt <= 4'd1;
      end else begin
        acc_buf <= '0;
        acc_cnt <= 4'd0;
      end
    end else begin
      if (dct_valid && dct_ready) begin
        dct_valid <= 1'b0;
      end
      if (flush_req && (acc_cnt != 4'd0)) begin
        flush_pend <= 1'b1;
      end
      if (accept) begin
        acc_buf <= acc_buf_ins;
        acc_cnt <= acc_cnt + 4'd1;
      end
    end
  end

`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_ovf_cnt <= 8'd0;
    end else if (flush_req && xfer) begin
      dct_ovf_cnt <= 8'd0;
    end else if (atm_valid && !atm_ready && (dct_ovf_cnt != 8'hff)) begin
      dct_ovf_cnt <= dct_ovf_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Directed self-checking bench for nios2_oci_dct_packer; inputs change 1 time unit after the rising edge.
module tb_nios2_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        atm_valid;
  logic [2:0]  atm;
  logic        atm_ready;
  logic        flush;
  logic        test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready;
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
  logic [7:0]  dct_ovf_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int          idx;
  logic [29:0] got_buf[$];
  logic [3:0]  got_cnt[$];

  always #5 clk = ~clk;

  nios2_oci_dct_packer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .atm_valid   (atm_valid),
    .atm         (atm),
    .atm_ready   (atm_ready),
    .flush       (flush),
    .test_ending (test_ending),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .dct_valid   (dct_valid),
    .dct_ready   (dct_ready)
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
    ,
    .dct_ovf_cnt (dct_ovf_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] atom_of(int i);
    return 3'((i * 5 + 3) % 8);
  endfunction

  function automatic logic [29:0] exp_word(int first, int n);
    logic [29:0] w = '0;
    for (int j = 0; j < n; j++) w[3*j +: 3] = atom_of(first + j);
    return w;
  endfunction

  // one cycle of the backpressure scenario: offer atom idx, collect any consumed word
  task automatic bp_cycle();
    logic r;
    atm_valid = (idx < 25);
    atm       = atom_of(idx);
    @(negedge clk);
    r = atm_ready;
    if (dct_valid && dct_ready) begin
      got_buf.push_back(dct_buffer);
      got_cnt.push_back(dct_count);
    end
    @(posedge clk);
    #1;
    if (atm_valid && r) idx++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; atm_valid = 1'b0; atm = 3'd0; flush = 1'b0;
    test_ending = 1'b0; dct_ready = 1'b0;
    #2;
    n_checks++; if (dct_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", dct_valid); end
    n_checks++; if (dct_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", dct_count); end
    n_checks++; if (dct_buffer !== 30'd0) begin n_fail++; $display("FAIL reset_buffer got=%o exp=0", dct_buffer); end
    n_checks++; if (atm_ready !== 1'b1) begin n_fail++; $display("FAIL reset_atm_ready got=%b exp=1", atm_ready); end
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
    n_checks++; if (dct_ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ovf got=%0d exp=0", dct_ovf_cnt); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_word();
    int v[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    int pulses = 0;
    dct_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      atm_valid = 1'b1;
      atm = 3'(v[i]);
      #1;
      n_checks++; if (atm_ready !== 1'b1) begin n_fail++; $display("FAIL full_atm_ready slot=%0d got=%b exp=1", i, atm_ready); end
      tick();
      if (dct_valid) pulses++;
    end
    atm_valid = 1'b0;
    tick();
    if (dct_valid) pulses++;
    n_checks++; if (dct_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got=%b exp=1", dct_valid); end
    n_checks++; if (dct_count !== 4'd10) begin n_fail++; $display("FAIL full_count got=%0d exp=10", dct_count); end
    n_checks++; if (dct_buffer !== 30'o2107654321) begin n_fail++; $display("FAIL full_buffer got=%o exp=2107654321", dct_buffer); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dct_valid) pulses++;
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL full_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_flush();
    int v[3] = '{5, 6, 7};
    dct_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      atm_valid = 1'b1;
      atm = 3'(v[i]);
      tick();
    end
    atm_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (dct_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid got=%b exp=1", dct_valid); end
    n_checks++; if (dct_count !== 4'd3) begin n_fail++; $display("FAIL flush_count got=%0d exp=3", dct_count); end
    n_checks++; if (dct_buffer !== 30'o765) begin n_fail++; $display("FAIL flush_buffer got=%o exp=765", dct_buffer); end
    tick();
    n_checks++; if (dct_valid !== 1'b0) begin n_fail++; $display("FAIL flush_consumed got=%b exp=0", dct_valid); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    n_checks++; if (dct_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid got=%b exp=0", dct_valid); end
    n_checks++; if (dct_count !== 4'd3) begin n_fail++; $display("FAIL flush_data_hold got=%0d exp=3", dct_count); end
  endtask

  task automatic test_backpressure();
    idx = 0;
    got_buf.delete();
    got_cnt.delete();
    dct_ready = 1'b0;
    for (int c = 0; c < 24; c++) bp_cycle();
    #1;
    n_checks++; if (idx !== 20) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=20", idx); end
    n_checks++; if (atm_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready got=%b exp=0", atm_ready); end
    n_checks++; if (dct_valid !== 1'b1) begin n_fail++; $display("FAIL bp_held_valid got=%b exp=1", dct_valid); end
    n_checks++; if (dct_buffer !== exp_word(0, 10)) begin n_fail++; $display("FAIL bp_held_word got=%o exp=%o", dct_buffer, exp_word(0, 10)); end
    dct_ready = 1'b1;
    for (int c = 0; c < 40 && !(idx == 25 && got_buf.size() == 2); c++) bp_cycle();
    atm_valid = 1'b0;
    n_checks++; if (idx !== 25) begin n_fail++; $display("FAIL bp_all_accepted got=%0d exp=25", idx); end
    for (int c = 0; c < 5; c++) begin
      flush = (c == 0);
      @(negedge clk);
      if (dct_valid && dct_ready) begin
        got_buf.push_back(dct_buffer);
        got_cnt.push_back(dct_count);
      end
      tick();
    end
    flush = 1'b0;
    n_checks++; if (got_buf.size() !== 3) begin n_fail++; $display("FAIL bp_word_count got=%0d exp=3", got_buf.size()); end
    for (int k = 0; k < got_buf.size() && k < 3; k++) begin
      n_checks++;
      if (got_buf[k] !== exp_word(10 * k, (k == 2) ? 5 : 10) || got_cnt[k] !== ((k == 2) ? 4'd5 : 4'd10)) begin
        n_fail++;
        $display("FAIL bp_word%0d got=%o/%0d exp=%o/%0d", k, got_buf[k], got_cnt[k],
                 exp_word(10 * k, (k == 2) ? 5 : 10), (k == 2) ? 5 : 10);
      end
    end
  endtask

  task automatic test_back_to_back();
    dct_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      atm_valid = 1'b1;
      atm = 3'(i % 8);
      tick();
    end
    atm = 3'd6;
    #1;
    n_checks++; if (atm_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_on_xfer got=%b exp=1", atm_ready); end
    tick();
    atm_valid = 1'b0;
    n_checks++; if (dct_count !== 4'd10 || dct_buffer !== 30'o1076543210) begin n_fail++; $display("FAIL b2b_full_word got=%o/%0d exp=1076543210/10", dct_buffer, dct_count); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (dct_valid !== 1'b1 || dct_count !== 4'd1 || dct_buffer !== 30'o6) begin n_fail++; $display("FAIL b2b_slot0 got=%b/%0d/%o exp=1/1/6", dct_valid, dct_count, dct_buffer); end
    tick();
  endtask

  task automatic test_test_ending();
    dct_ready = 1'b1;
    test_ending = 1'b1;
    atm_valid = 1'b1;
    atm = 3'd1;
    tick();
    atm = 3'd2;
    tick();
    n_checks++; if (dct_valid !== 1'b1 || dct_count !== 4'd1 || dct_buffer !== 30'o1) begin n_fail++; $display("FAIL te_word1 got=%b/%0d/%o exp=1/1/1", dct_valid, dct_count, dct_buffer); end
    atm = 3'd3;
    tick();
    n_checks++; if (dct_valid !== 1'b1 || dct_count !== 4'd1 || dct_buffer !== 30'o2) begin n_fail++; $display("FAIL te_word2 got=%b/%0d/%o exp=1/1/2", dct_valid, dct_count, dct_buffer); end
    atm_valid = 1'b0;
    tick();
    n_checks++; if (dct_valid !== 1'b1 || dct_count !== 4'd1 || dct_buffer !== 30'o3) begin n_fail++; $display("FAIL te_word3 got=%b/%0d/%o exp=1/1/3", dct_valid, dct_count, dct_buffer); end
    tick();
    n_checks++; if (dct_valid !== 1'b0) begin n_fail++; $display("FAIL te_idle_valid got=%b exp=0", dct_valid); end
    atm_valid = 1'b1;
    atm = 3'd5;
    tick();
    atm_valid = 1'b0;
    tick();
    n_checks++; if (dct_valid !== 1'b1 || dct_count !== 4'd1 || dct_buffer !== 30'o5) begin n_fail++; $display("FAIL te_sparse got=%b/%0d/%o exp=1/1/5", dct_valid, dct_count, dct_buffer); end
    test_ending = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    dct_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      atm_valid = 1'b1;
      atm = 3'd7;
      tick();
    end
    atm_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      atm_valid = 1'b1;
      atm = 3'd1;
      tick();
    end
    atm_valid = 1'b0;
    n_checks++; if (dct_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got=%b exp=1", dct_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (dct_valid !== 1'b0 || dct_count !== 4'd0 || dct_buffer !== 30'd0) begin n_fail++; $display("FAIL rst_async got=%b/%0d/%o exp=0/0/0", dct_valid, dct_count, dct_buffer); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    dct_ready = 1'b1;
    atm_valid = 1'b1;
    atm = 3'd4;
    tick();
    atm_valid = 1'b0;
    n_checks++; if (dct_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_partial got=%b exp=0", dct_valid); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (dct_count !== 4'd1 || dct_buffer !== 30'o4) begin n_fail++; $display("FAIL rst_restart got=%0d/%o exp=1/4", dct_count, dct_buffer); end
    tick();
  endtask

`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
  task automatic test_ovf_cnt();
    dct_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      atm_valid = 1'b1;
      atm = 3'd2;
      tick();
    end
    atm_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      atm_valid = 1'b1;
      atm = 3'd3;
      tick();
    end
    n_checks++; if (dct_ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL ovf_pre got=%0d exp=0", dct_ovf_cnt); end
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (dct_ovf_cnt !== 8'd4) begin n_fail++; $display("FAIL ovf_count got=%0d exp=4", dct_ovf_cnt); end
    atm_valid = 1'b0;
    dct_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (dct_ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL ovf_clear got=%0d exp=0", dct_ovf_cnt); end
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_test_ending();
    test_reset_mid();
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
    test_ovf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
